timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_pkg.sv | 68 ++++++
 rtl/timer_prescaler.sv | 43 ++++
 rtl/timer_counter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer/counter: register map, CTRL/STATUS
// bit positions, reset constants and the prescaler terminal-count helper.
package timer_pkg;

    // Register offsets inside the 4-byte window (address bits [1:0]).
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_e;

    // CTRL bit positions; bit 7 is unimplemented and always reads 0.
    localparam int CTRL_EN     = 0;
    localparam int CTRL_PS_LSB = 1;
    localparam int CTRL_PS_MSB = 3;
    localparam int CTRL_CTC    = 4;
    localparam int CTRL_OVIE   = 5;
    localparam int CTRL_CMIE   = 6;

    // STATUS bit positions; bits [7:2] always read 0.
    localparam int STAT_OVF = 0;
    localparam int STAT_CMF = 1;

    // Reset value of the compare register.
    localparam logic [7:0] CMP_RST = 8'hFF;

    // Width of the prescaler counter: PS=7 needs a 128-cycle period.
    localparam int PRESC_W = 7;

    // Stored CTRL bits, laid out so that the packed value equals CTRL[6:0].
    typedef struct packed {
        logic       cmie;
        logic       ovie;
        logic       ctc;
        logic [2:0] ps;
        logic       en;
    } ctrl_t;

    // Terminal count of the prescaler for a prescale select: (2^ps)-1.
    function automatic logic [PRESC_W-1:0] ps_limit(input logic [2:0] ps);
        logic [PRESC_W:0] full;
        full = (8'd1 << ps) - 8'd1;
        return full[PRESC_W-1:0];
    endfunction

    // Assemble the CTRL read value from the stored fields.
    function automatic logic [7:0] ctrl_rd(input ctrl_t c);
        logic [7:0] v;
        v                          = 8'h00;
        v[CTRL_EN]                 = c.en;
        v[CTRL_PS_MSB:CTRL_PS_LSB] = c.ps;
        v[CTRL_CTC]                = c.ctc;
        v[CTRL_OVIE]               = c.ovie;
        v[CTRL_CMIE]               = c.cmie;
        return v;
    endfunction

    // Assemble the STATUS read value from the two flags.
    function automatic logic [7:0] status_rd(input logic ovf, input logic cmf);
        logic [7:0] v;
        v           = 8'h00;
        v[STAT_OVF] = ovf;
        v[STAT_CMF] = cmf;
        return v;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: a 7-bit counter that runs while enabled and emits
// a one-cycle tick when it reaches (2^ps)-1, reloading to zero afterwards.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] ps,
    input  logic       clr,
    output logic       tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    // The tick is decoded from the current count so it lines up with the
    // cycle in which the count sits at its terminal value.
    assign tick = en && (cnt_q == ps_limit(ps));

    // Next count: explicit clear has priority, then reload on tick, then
    // advance only while enabled (a disabled prescaler holds its value).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler count register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped 8-bit timer/counter with prescaler, compare match,
// clear-on-compare, overflow/compare flags and a level interrupt request.
module timer_counter
    import timer_pkg::*;
#(
    // Byte address of register 0; must be 4-byte aligned inside 0x1000-0x10FF.
    parameter logic [15:0] BASE_ADDR = 16'h1040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] dMemIOAddress,
    input  logic [7:0]  dMemIOIn,
    input  logic        dMemIOWriteEn,
    input  logic        dMemIOReadEn,
    output logic [7:0]  rdata,
    output logic        interrupt,
    input  logic        interrupt_clr
);

    // Architectural state.
    ctrl_t      ctrl_q,  ctrl_d;
    logic [7:0] count_q, count_d;
    logic [7:0] cmp_q,   cmp_d;
    logic       ovf_q,   ovf_d;
    logic       cmf_q,   cmf_d;
    logic [7:0] rdata_q, rdata_d;

    // Bus decode.
    logic       sel;
    reg_off_e   offset;
    logic       wr_ctrl, wr_count, wr_cmp, wr_status;
    logic       rd_en;
    ctrl_t      ctrl_wdata;

    // Counter events.
    logic       tick;
    logic       presc_clr;
    logic       match;
    logic       ovf_set, cmf_set;
    logic [7:0] count_inc;

    // Address window and per-register write strobes.
    always_comb begin
        sel       = (dMemIOAddress[15:2] == BASE_ADDR[15:2]);
        offset    = reg_off_e'(dMemIOAddress[1:0]);
        rd_en     = sel && dMemIOReadEn;
        wr_ctrl   = sel && dMemIOWriteEn && (offset == REG_CTRL);
        wr_count  = sel && dMemIOWriteEn && (offset == REG_COUNT);
        wr_cmp    = sel && dMemIOWriteEn && (offset == REG_CMP);
        wr_status = sel && dMemIOWriteEn && (offset == REG_STATUS);

        // CTRL[7] has no storage, so it simply never reaches the register.
        ctrl_wdata.en   = dMemIOIn[CTRL_EN];
        ctrl_wdata.ps   = dMemIOIn[CTRL_PS_MSB:CTRL_PS_LSB];
        ctrl_wdata.ctc  = dMemIOIn[CTRL_CTC];
        ctrl_wdata.ovie = dMemIOIn[CTRL_OVIE];
        ctrl_wdata.cmie = dMemIOIn[CTRL_CMIE];
    end

    // Restart the prescaler when COUNT is reloaded, when PS changes, or when
    // the timer is being disabled, so the next interval is always a full one.
    always_comb begin
        presc_clr = wr_count
                 || (wr_ctrl && ((ctrl_wdata.ps != ctrl_q.ps) || !ctrl_wdata.en));
    end

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_q.en),
        .ps    (ctrl_q.ps),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // Count update on a tick: a compare match with CTC reloads to zero and
    // cannot overflow; otherwise the count increments and the 0xFF->0x00
    // wrap raises OVF. A bus write to COUNT replaces the count update but the
    // flag events of that tick still stand.
    always_comb begin
        match     = (count_q == cmp_q);
        count_inc = count_q + 8'd1;
        count_d   = count_q;
        ovf_set   = 1'b0;
        cmf_set   = 1'b0;
        if (tick) begin
            cmf_set = match;
            if (match && ctrl_q.ctc) begin
                count_d = 8'h00;
            end else begin
                count_d = count_inc;
                ovf_set = (count_q == 8'hFF);
            end
        end
        if (wr_count) begin
            count_d = dMemIOIn;
        end
    end

    // Register writes for CTRL and CMP.
    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        if (wr_ctrl) begin
            ctrl_d = ctrl_wdata;
        end
        if (wr_cmp) begin
            cmp_d = dMemIOIn;
        end
    end

    // Flag update: clears from a STATUS write-1 or an interrupt acknowledge
    // (only for flags whose interrupt is enabled), then a same-cycle set wins.
    always_comb begin
        ovf_d = ovf_q;
        cmf_d = cmf_q;
        if (wr_status && dMemIOIn[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_status && dMemIOIn[STAT_CMF]) begin
            cmf_d = 1'b0;
        end
        if (interrupt_clr && ctrl_q.ovie) begin
            ovf_d = 1'b0;
        end
        if (interrupt_clr && ctrl_q.cmie) begin
            cmf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (cmf_set) begin
            cmf_d = 1'b1;
        end
    end

    // Read data mux built from current register values, so a read coinciding
    // with a write returns the pre-write contents; idle cycles return zero
    // so the output can be ORed onto a shared bus.
    always_comb begin
        rdata_d = 8'h00;
        if (rd_en) begin
            unique case (offset)
                REG_CTRL:   rdata_d = ctrl_rd(ctrl_q);
                REG_COUNT:  rdata_d = count_q;
                REG_CMP:    rdata_d = cmp_q;
                REG_STATUS: rdata_d = status_rd(ovf_q, cmf_q);
            endcase
        end
    end

    // All state registers, asynchronously reset to their documented values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            count_q <= 8'h00;
            cmp_q   <= CMP_RST;
            ovf_q   <= 1'b0;
            cmf_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ovf_q   <= ovf_d;
            cmf_q   <= cmf_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign interrupt = (ovf_q && ctrl_q.ovie) || (cmf_q && ctrl_q.cmie);

endmodule
